// File: rtl/run_detect_pkg.sv
// Shared types for the run detector: FSM state codes, mode encodings and
// the polarity-enable helper used by the detector FSM.
package run_detect_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_HIT  = 2'd2;

    typedef logic [1:0] mode_t;
    localparam mode_t MODE_BOTH  = 2'b00;
    localparam mode_t MODE_ZEROS = 2'b01;
    localparam mode_t MODE_ONES  = 2'b10;
    localparam mode_t MODE_OFF   = 2'b11;

    function automatic logic mode_enables(input mode_t mode, input logic bit_val);
        logic en_s;
        case (mode)
            MODE_BOTH:  en_s = 1'b1;
            MODE_ZEROS: en_s = ~bit_val;
            MODE_ONES:  en_s = bit_val;
            default:    en_s = 1'b0;
        endcase
        return en_s;
    endfunction

endpackage

// File: rtl/run_detect_if.sv
// Sample/result bundle of the run detector; the detector is the slave side.
interface run_detect_if
    import run_detect_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(RUN_LEN + 1);

    logic             in_valid;
    logic             in_bit;
    mode_t            mode;
    logic             overlap;
    logic             det;
    logic             det_level;
    logic             det_val;
    logic [LEN_W-1:0] run_len;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output in_valid, in_bit, mode, overlap,
        input  det, det_level, det_val, run_len, hit_cnt
    );

    modport slave (
        input  in_valid, in_bit, mode, overlap,
        output det, det_level, det_val, run_len, hit_cnt
    );
endinterface

// File: rtl/run_detect_sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear, async active-low reset.
module sat_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] q
);
    localparam logic [width-1:0] Q_MAX = {width{1'b1}};

    logic [width-1:0] q_r;

    // Count increments, clearing on clr and sticking at the maximum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r <= {width{1'b0}};
        end else if (clr) begin
            q_r <= {width{1'b0}};
        end else if (inc && (q_r != Q_MAX)) begin
            q_r <= q_r + width'(1'b1);
        end
    end

    assign q = q_r;
endmodule

// File: rtl/run_detect.sv
// Serial run detector: flags RUN_LEN consecutive equal samples of an enabled
// polarity, optionally re-hitting on every further equal sample.
module run_detect
    import run_detect_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    run_detect_if.slave bus
);
    localparam int LEN_W = $clog2(RUN_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(RUN_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);

    state_t           state_r, state_s;
    logic [LEN_W-1:0] run_len_r, run_len_s;
    logic             last_r, last_s;
    logic             hit_s;
    logic             det_r, det_level_r, det_val_r;
    logic [CNT_W-1:0] hit_cnt_s;

    // Next-state, run length and hit decision for the current sample
    always_comb begin
        state_s   = state_r;
        run_len_s = run_len_r;
        last_s    = last_r;
        hit_s     = 1'b0;
        if (bus.in_valid) begin
            case (state_r)
                ST_IDLE: begin
                    last_s    = bus.in_bit;
                    run_len_s = LEN_ONE;
                    state_s   = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.in_bit == last_r) begin
                        if (run_len_r < LEN_MAX) begin
                            run_len_s = run_len_r + LEN_ONE;
                        end else begin
                            run_len_s = LEN_MAX;
                        end
                        if ((run_len_s == LEN_MAX) && mode_enables(bus.mode, bus.in_bit)) begin
                            hit_s   = 1'b1;
                            state_s = ST_HIT;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        last_s    = bus.in_bit;
                        run_len_s = LEN_ONE;
                        state_s   = ST_RUN;
                    end
                end
                ST_HIT: begin
                    // Only an equal bit with overlap keeps the run alive past a hit
                    if (bus.overlap && (bus.in_bit == last_r)) begin
                        run_len_s = LEN_MAX;
                        if (mode_enables(bus.mode, bus.in_bit)) begin
                            hit_s   = 1'b1;
                            state_s = ST_HIT;
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        last_s    = bus.in_bit;
                        run_len_s = LEN_ONE;
                        state_s   = ST_RUN;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    run_len_s = {LEN_W{1'b0}};
                    last_s    = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs; clear behaves like a synchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            run_len_r   <= {LEN_W{1'b0}};
            last_r      <= 1'b0;
            det_r       <= 1'b0;
            det_level_r <= 1'b0;
            det_val_r   <= 1'b0;
        end else if (clear) begin
            state_r     <= ST_IDLE;
            run_len_r   <= {LEN_W{1'b0}};
            last_r      <= 1'b0;
            det_r       <= 1'b0;
            det_level_r <= 1'b0;
            det_val_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            run_len_r   <= run_len_s;
            last_r      <= last_s;
            det_r       <= hit_s;
            det_level_r <= (state_s == ST_HIT);
            if (hit_s) begin
                det_val_r <= bus.in_bit;
            end
        end
    end

    sat_counter #(.width(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (hit_s),
        .q   (hit_cnt_s)
    );

    assign bus.det       = det_r;
    assign bus.det_level = det_level_r;
    assign bus.det_val   = det_val_r;
    assign bus.run_len   = run_len_r;
    assign bus.hit_cnt   = hit_cnt_s;
endmodule

// File: tb/tb_run_detect.sv
// Scoreboard bench for run_detect: two instances (8-bit and 2-bit hit counters)
// share stimulus; a run-length reference model feeds an expectation queue.
module tb_run_detect;
    import run_detect_pkg::*;

    localparam int RL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       overlap = 1'b0;

    always #5 clk = ~clk;

    run_detect_if #(.RUN_LEN(RL), .CNT_W(8)) bus_a ();
    run_detect_if #(.RUN_LEN(RL), .CNT_W(2)) bus_b ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.in_bit   = in_bit;
    assign bus_a.mode     = mode;
    assign bus_a.overlap  = overlap;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_bit   = in_bit;
    assign bus_b.mode     = mode;
    assign bus_b.overlap  = overlap;

    run_detect #(.RUN_LEN(RL), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .clear(clear), .bus(bus_a.slave));
    run_detect #(.RUN_LEN(RL), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .clear(clear), .bus(bus_b.slave));

    typedef struct {
        logic det;
        logic det_level;
        logic det_val;
        int   run_len;
        int   cnt_a;
        int   cnt_b;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   det_b_seen = 0;

    // Reference model: true (unsaturated) run length since the last restart
    bit m_started, m_last, m_hit, m_det_val;
    int m_len, m_cnt;

    logic [1:0] cur_mode = 2'b00;
    logic       cur_ov = 1'b0;
    logic       cur_bit = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    endtask

    function automatic bit polarity_on(input logic [1:0] md, input bit b);
        return (md == 2'd0) || (md == 2'd1 && !b) || (md == 2'd2 && b);
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_started = 1'b0; m_last = 1'b0; m_hit = 1'b0; m_det_val = 1'b0;
        m_len = 0; m_cnt = 0;
    endtask

    task automatic step(input bit v, input bit b, input logic [1:0] md, input bit ov, input bit clr);
        exp_t e;
        bit   det;
        @(negedge clk);
        in_valid = v; in_bit = b; mode = md; overlap = ov; clear = clr;
        det = 1'b0;
        if (clr) begin
            model_reset();
        end else if (v) begin
            if (!m_started) begin
                m_started = 1'b1;
                m_len = 1;
            end else if (b != m_last || (m_hit && !ov)) begin
                m_len = 1;
            end else begin
                m_len = m_len + 1;
            end
            m_last = b;
            m_hit = (m_len >= RL) && polarity_on(md, b);
            if (m_hit) begin
                m_cnt++;
                m_det_val = b;
            end
            det = m_hit;
        end
        e.det = det; e.det_level = m_hit; e.det_val = m_det_val;
        e.run_len = min_i(m_len, RL);
        e.cnt_a = min_i(m_cnt, 255);
        e.cnt_b = min_i(m_cnt, 3);
        exp_q.push_back(e);
    endtask

    task automatic samp(input bit b);
        step(1'b1, b, cur_mode, cur_ov, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, cur_bit, cur_mode, cur_ov, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b0, cur_mode, cur_ov, 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_det"}, bus_a.det, 0);
        chk({tag, "_det_level"}, bus_a.det_level, 0);
        chk({tag, "_det_val"}, bus_a.det_val, 0);
        chk({tag, "_run_len"}, bus_a.run_len, 0);
        chk({tag, "_hit_cnt_a"}, bus_a.hit_cnt, 0);
        chk({tag, "_hit_cnt_b"}, bus_b.hit_cnt, 0);
    endtask

    // Asynchronous reset pulse between clock edges, outputs checked while low
    task automatic rst_pulse();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_vals("async_rst");
        #1 rst = 1'b1;
        model_reset();
    endtask

    // Monitor: compare each cycle's outputs against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("det_a", bus_a.det, e.det);
                chk("det_level_a", bus_a.det_level, e.det_level);
                chk("det_val_a", bus_a.det_val, e.det_val);
                chk("run_len_a", bus_a.run_len, e.run_len);
                chk("hit_cnt_a", bus_a.hit_cnt, e.cnt_a);
                chk("det_b", bus_b.det, e.det);
                chk("run_len_b", bus_b.run_len, e.run_len);
                chk("hit_cnt_b", bus_b.hit_cnt, e.cnt_b);
                if (bus_b.det) det_b_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #2 check_reset_vals("por");
        #1 rst = 1'b1;

        // Four zeros, no overlap
        cur_mode = 2'b00; cur_ov = 1'b0;
        do_clear();
        repeat (4) samp(1'b0);
        idle(2);

        // Six ones with overlap: hits on samples 4..6
        cur_ov = 1'b1;
        do_clear();
        repeat (6) samp(1'b1);
        idle(2);

        // Zeros-only polarity
        cur_mode = 2'b01; cur_ov = 1'b0;
        do_clear();
        repeat (5) samp(1'b1);
        repeat (4) samp(1'b0);
        idle(1);

        // Broken run, then the same with idle gaps
        cur_mode = 2'b00;
        do_clear();
        samp(1'b1); samp(1'b1); samp(1'b1); samp(1'b0);
        do_clear();
        samp(1'b1); idle(10); samp(1'b1); idle(10); samp(1'b1); idle(10); samp(1'b0);
        idle(1);

        // Partial run discarded by reset, then by clear
        do_clear();
        repeat (3) samp(1'b0);
        rst_pulse();
        samp(1'b0);
        idle(1);
        repeat (3) samp(1'b0);
        do_clear();
        samp(1'b0);
        idle(1);

        // Ten ones with overlap: 2-bit counter saturates while det keeps pulsing
        cur_ov = 1'b1;
        do_clear();
        det_b_seen = 0;
        repeat (10) samp(1'b1);
        idle(1);
        @(posedge clk);
        #2;
        chk("sat_hit_cnt_b", bus_b.hit_cnt, 3);
        chk("sat_det_pulses_b", det_b_seen, 7);
        chk("sat_hit_cnt_a", bus_a.hit_cnt, 7);

        // Mode disabled inside a hit drops back to counting
        cur_mode = 2'b00;
        repeat (2) samp(1'b1);
        cur_mode = 2'b11;
        repeat (2) samp(1'b1);
        cur_mode = 2'b10;
        samp(1'b1);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 255);
            if (r < 4) begin
                step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, cur_mode, cur_ov, 1'b1);
            end else if (r == 4) begin
                rst_pulse();
            end else begin
                if ($urandom_range(0, 15) == 0) cur_mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) cur_ov = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) cur_bit = ~cur_bit;
                step($urandom_range(0, 3) != 0, cur_bit, cur_mode, cur_ov, 1'b0);
            end
        end

        idle(3);
        @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
